// File: rtl/ofmap_quant_if.sv
// ofmap_quant_if: handshake bundle between the conv engine, ofmap_quant and the downstream consumer.
//   cfg_dat/cfg_vld/cfg_rdy       per-layer config {relu_en, shift[4:0]}
//   ofmap_dat/ofmap_vld/ofmap_rdy 32-bit signed conv results into the quantizer
//   out_dat/out_vld/out_rdy       16-bit quantized results from the FIFO head
//   done                          one-cycle pulse when a layer has fully drained
//   sat_count                     saturation events since the last config accept
interface ofmap_quant_if;
    logic [5:0]  cfg_dat;
    logic        cfg_vld;
    logic        cfg_rdy;
    logic [31:0] ofmap_dat;
    logic        ofmap_vld;
    logic        ofmap_rdy;
    logic [15:0] out_dat;
    logic        out_vld;
    logic        out_rdy;
    logic        done;
    logic [31:0] sat_count;
    modport master (
        output cfg_dat, cfg_vld, ofmap_dat, ofmap_vld, out_rdy,
        input  cfg_rdy, ofmap_rdy, out_dat, out_vld, done, sat_count
    );
    modport slave (
        input  cfg_dat, cfg_vld, ofmap_dat, ofmap_vld, out_rdy,
        output cfg_rdy, ofmap_rdy, out_dat, out_vld, done, sat_count
    );
endinterface

// File: rtl/ofmap_quant.sv
// ofmap_quant: ReLU / arithmetic shift / 16-bit saturation of the conv ofmap stream through a 2-entry FIFO.
//   clk  clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  ofmap_quant_if.slave: cfg, ofmap in, quantized out, done pulse, sat_count
module ofmap_quant #(
    parameter int OFMAP_SIZE = 802816,
    parameter int CNT_W      = $clog2(OFMAP_SIZE + 1)
) (
    input  logic         clk,
    input  logic         rst,
    ofmap_quant_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_relu;
    logic [4:0]         r_shift;
    logic [31:0]        r_sat;
    logic [15:0]        r_mem [2];
    logic               r_rd, r_wr;
    logic [1:0]         r_fcnt;
    logic [15:0]        r_last;
    logic               w_cfg_xfer, w_in_xfer, w_out_xfer, w_last_word;
    logic signed [31:0] w_shr, w_y;
    logic               w_hi, w_lo;
    logic [15:0]        w_q;
    assign w_cfg_xfer  = bus.cfg_vld & bus.cfg_rdy;
    assign w_in_xfer   = bus.ofmap_vld & bus.ofmap_rdy;
    assign w_out_xfer  = bus.out_vld & bus.out_rdy;
    assign w_last_word = r_cnt == CNT_W'(OFMAP_SIZE - 1);
    // >>> on a signed operand floors toward -inf, which is the required rounding
    assign w_shr = $signed(bus.ofmap_dat) >>> r_shift;
    assign w_y   = (r_relu & bus.ofmap_dat[31]) ? 32'sd0 : w_shr;
    // out of 16-bit range iff bits [30:15] are not a pure sign extension
    assign w_hi  = ~w_y[31] & (w_y[30:15] != 16'h0000);
    assign w_lo  = w_y[31] & (w_y[30:15] != 16'hFFFF);
    assign w_q   = w_hi ? 16'h7FFF : w_lo ? 16'h8000 : w_y[15:0];
    always_comb begin
        w_next        = r_state;
        bus.cfg_rdy   = r_state == IDLE;
        bus.ofmap_rdy = (r_state == RUN) & (r_fcnt != 2'd2);
        bus.done      = r_state == DONE;
        bus.out_vld   = r_fcnt != 2'd0;
        // empty FIFO keeps presenting the last value that left it
        bus.out_dat   = bus.out_vld ? r_mem[r_rd] : r_last;
        bus.sat_count = r_sat;
        case (r_state)
            IDLE:    w_next = w_cfg_xfer ? RUN : IDLE;
            RUN:     w_next = (w_in_xfer & w_last_word) ? DRAIN : RUN;
            DRAIN:   w_next = (r_fcnt == 2'd0) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_relu   <= 1'b0;
            r_shift  <= '0;
            r_sat    <= '0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_fcnt   <= '0;
            r_last   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cfg_xfer) begin
                r_relu  <= bus.cfg_dat[5];
                r_shift <= bus.cfg_dat[4:0];
                r_cnt   <= '0;
                r_sat   <= '0;
            end
            if (w_in_xfer) begin
                r_cnt        <= r_cnt + CNT_W'(1);
                r_mem[r_wr]  <= w_q;
                r_wr         <= ~r_wr;
                if ((w_hi | w_lo) & (r_sat != 32'hFFFF_FFFF))
                    r_sat <= r_sat + 32'd1;
            end
            if (w_out_xfer) begin
                r_rd   <= ~r_rd;
                r_last <= r_mem[r_rd];
            end
            r_fcnt <= r_fcnt + 2'(w_in_xfer) - 2'(w_out_xfer);
        end
    end
endmodule

// File: tb/tb_ofmap_quant.sv
// tb_ofmap_quant: directed and randomized checks of ofmap_quant against a queue-based reference model.
module tb_ofmap_quant;
    localparam int SIZE = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ofmap_quant_if bus ();
    ofmap_quant #(.OFMAP_SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int          vectors = 0;
    int          miscompares = 0;
    int          m_phase = 0;
    int          m_acc = 0;
    int          m_words = 0;
    bit          m_relu = 0;
    int          m_sh = 0;
    logic [31:0] m_sat = 0;
    logic [15:0] m_last = 0;
    logic [15:0] q[$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [15:0] quant(input logic [31:0] d);
        longint x  = longint'($signed(d));
        longint dv = longint'(1) << m_sh;
        longint y;
        if (m_relu && x < 0) y = 0;
        else begin
            y = x / dv;
            if (x < 0 && y * dv != x) y = y - 1;
        end
        if (y > 32767 || y < -32768) begin
            if (m_sat != 32'hFFFF_FFFF) m_sat = m_sat + 1;
            return (y > 0) ? 16'h7FFF : 16'h8000;
        end
        return 16'(y);
    endfunction
    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_acc = 0;
        m_relu = 0;
        m_sh = 0;
        m_sat = 0;
        m_last = 0;
    endtask
    task automatic cyc(input bit r, input bit cv, input logic [5:0] cd,
                       input bit ov, input logic [31:0] od, input bit ordy);
        int qn;
        bit cx, ox, px;
        rst = r;
        bus.cfg_vld = cv;
        bus.cfg_dat = cd;
        bus.ofmap_vld = ov;
        bus.ofmap_dat = od;
        bus.out_rdy = ordy;
        @(negedge clk);
        qn = q.size();
        chk("cfg_rdy", 32'(bus.cfg_rdy), 32'(m_phase == 0));
        chk("ofmap_rdy", 32'(bus.ofmap_rdy), 32'(m_phase == 1 && qn < 2));
        chk("out_vld", 32'(bus.out_vld), 32'(qn > 0));
        chk("out_dat", 32'(bus.out_dat), 32'(qn > 0 ? q[0] : m_last));
        chk("done", 32'(bus.done), 32'(m_phase == 3));
        chk("sat_count", bus.sat_count, m_sat);
        cx = cv && m_phase == 0;
        ox = ov && m_phase == 1 && qn < 2;
        px = ordy && qn > 0;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else begin
            if (px) m_last = q.pop_front();
            case (m_phase)
                0: if (cx) begin
                    m_phase = 1;
                    m_acc = 0;
                    m_sat = 0;
                    m_relu = cd[5];
                    m_sh = int'(cd[4:0]);
                end
                1: if (ox) begin
                    q.push_back(quant(od));
                    m_acc++;
                    m_words++;
                    if (m_acc == SIZE) m_phase = 2;
                end
                2: if (qn == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    endtask
    task automatic finish_layer();
        int i;
        for (i = 0; i < 60 && m_phase != 0; i++) cyc(0, 0, 6'd0, 1, 32'd0, 1);
        chk("layer_timeout", 32'(i < 60), 32'd1);
    endtask
    initial begin
        logic [31:0] d;
        bus.cfg_vld = 0;
        bus.cfg_dat = 0;
        bus.ofmap_vld = 0;
        bus.ofmap_dat = 0;
        bus.out_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        chk("rst_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
        chk("rst_ofmap_rdy", 32'(bus.ofmap_rdy), 32'd0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_out_dat", 32'(bus.out_dat), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sat", bus.sat_count, 32'd0);
        // relu + shift 4
        cyc(0, 1, {1'b1, 5'd4}, 0, 0, 0);
        cyc(0, 0, 6'd0, 1, 32'h0000_0120, 0);
        cyc(0, 0, 6'd0, 1, 32'hFFFF_FF00, 0);
        chk("t1_head0", 32'(bus.out_dat), 32'h0012);
        cyc(0, 0, 6'd0, 0, 0, 1);
        chk("t1_head1", 32'(bus.out_dat), 32'h0000);
        chk("t1_sat", bus.sat_count, 32'd0);
        finish_layer();
        // saturation both ways
        cyc(0, 1, {1'b0, 5'd0}, 0, 0, 0);
        cyc(0, 0, 6'd0, 1, 32'h0001_2345, 0);
        cyc(0, 0, 6'd0, 1, 32'hFFFE_0000, 0);
        chk("t2_head0", 32'(bus.out_dat), 32'h7FFF);
        chk("t2_sat", bus.sat_count, 32'd2);
        cyc(0, 0, 6'd0, 0, 0, 1);
        chk("t2_head1", 32'(bus.out_dat), 32'h8000);
        finish_layer();
        // floor on negative shift, then backpressure with FIFO full
        cyc(0, 1, {1'b0, 5'd4}, 0, 0, 0);
        cyc(0, 0, 6'd0, 1, 32'hFFFF_FFF1, 0);
        cyc(0, 0, 6'd0, 1, 32'h0000_0100, 0);
        chk("t3_full_rdy", 32'(bus.ofmap_rdy), 32'd0);
        chk("t3_floor", 32'(bus.out_dat), 32'hFFFF);
        cyc(0, 0, 6'd0, 1, 32'h0000_0200, 0);
        cyc(0, 0, 6'd0, 1, 32'h0000_0200, 1);
        chk("t3_rdy_back", 32'(bus.ofmap_rdy), 32'd1);
        chk("t3_order", 32'(bus.out_dat), 32'h0010);
        cyc(0, 0, 6'd0, 1, 32'h0000_0300, 1);
        cyc(0, 0, 6'd0, 1, 32'h0000_0400, 1);
        finish_layer();
        // offer 6 words to a 4-word layer
        cyc(0, 1, {1'b0, 5'd1}, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 6'd0, 1, 32'(i * 2 + 2), 1);
        chk("t4_cap", 32'(m_acc), 32'(SIZE));
        chk("t4_rdy_low", 32'(bus.ofmap_rdy), 32'd0);
        finish_layer();
        // reset mid-layer with FIFO full
        cyc(0, 1, {1'b0, 5'd0}, 0, 0, 0);
        cyc(0, 0, 6'd0, 1, 32'h0000_7000, 0);
        cyc(0, 0, 6'd0, 1, 32'h0001_0000, 0);
        cyc(1, 0, 6'd0, 0, 0, 0);
        chk("t5_out_vld", 32'(bus.out_vld), 32'd0);
        chk("t5_ofmap_rdy", 32'(bus.ofmap_rdy), 32'd0);
        chk("t5_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
        chk("t5_sat", bus.sat_count, 32'd0);
        chk("t5_out_dat", 32'(bus.out_dat), 32'd0);
        repeat (4) cyc(0, 0, 6'd0, 1, 32'h5, 1);
        // random traffic
        m_words = 0;
        for (int c = 0; c < 30000 && m_words < 1000; c++) begin
            d = $urandom;
            if ($urandom_range(1, 0) == 1) d = 32'($signed(d) >>> $urandom_range(20, 0));
            cyc(0, $urandom_range(1, 0) == 1, 6'($urandom), $urandom_range(2, 0) != 0, d,
                $urandom_range(2, 0) != 0);
        end
        chk("rand_words", 32'(m_words >= 1000), 32'd1);
        finish_layer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
